// File: rtl/param_updown_counter_pkg.sv
// Shared constants and elaboration-time helpers for the up/down counter.
// Direction encoding and parameter legality live here so sub-blocks agree.
package cnt_pkg;

   localparam logic CNT_DOWN = 1'b0;
   localparam logic CNT_UP   = 1'b1;

   function automatic bit cfg_ok(input int unsigned width,
                                 input longint unsigned max_val,
                                 input int unsigned prescale);
      return (width >= 32'd2) && (width <= 32'd32) &&
             (max_val <= ((64'd1 << width) - 64'd1)) &&
             (prescale >= 32'd1) && (prescale <= 32'd65535);
   endfunction

   // A one-cycle prescale still needs a 1-bit register to keep the datapath uniform.
   function automatic int unsigned presc_w(input int unsigned prescale);
      return (prescale <= 32'd1) ? 32'd1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of param_updown_counter; master drives controls,
// slave (the counter) returns count, tc and ovf.
interface param_updown_counter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic             up_dn;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;

   modport master (output en, up_dn, clr, load, load_val,
                   input  count, tc, ovf);
   modport slave  (input  en, up_dn, clr, load, load_val,
                   output count, tc, ovf);
endinterface

// File: rtl/param_updown_counter_prescaler.sv
// Prescaler for param_updown_counter: one step per PRESCALE enabled cycles.
// With PRESCALE=1 the register stays at zero and step equals en.
module cnt_prescaler
   import cnt_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_clr,
   output logic step
);
   localparam int unsigned PW = presc_w(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 32'd1);

   logic [PW-1:0] phase;

   // Enabled-cycle counter; wraps on the cycle that emits a step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= '0;
      end else if (sync_clr) begin
         phase <= '0;
      end else if (en) begin
         if (phase == LAST) begin
            phase <= '0;
         end else begin
            phase <= phase + PW'(1'b1);
         end
      end else begin
         phase <= phase;
      end
   end

   assign step = en && (phase == LAST);

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with prescaler, terminal-count pulse and sticky
// overflow. Define PARAM_UPDOWN_COUNTER_SATURATE_EN to saturate at the bounds.
module param_updown_counter
   import cnt_pkg::*;
#(
   parameter int unsigned     WIDTH    = 8,
   parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
   parameter int unsigned     PRESCALE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   param_updown_counter_if.slave bus
);
   if (!cfg_ok(WIDTH, MAX, PRESCALE)) begin : g_bad_cfg
      $error("param_updown_counter: illegal WIDTH/MAX/PRESCALE combination");
   end

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
   localparam logic [WIDTH-1:0] BOUND_UP = MAX_V;
   localparam logic [WIDTH-1:0] BOUND_DN = '0;
`else
   localparam logic [WIDTH-1:0] BOUND_UP = '0;
   localparam logic [WIDTH-1:0] BOUND_DN = MAX_V;
`endif

   logic [WIDTH-1:0] count_q;
   logic             tc_q;
   logic             ovf_q;
   logic             step;
   logic [WIDTH-1:0] next_val;
   logic             at_bound;
   logic [WIDTH-1:0] load_clamped;

   cnt_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .sync_clr (bus.clr | bus.load),
      .step     (step)
   );

   // Value a step would produce, and whether that step hits a bound.
   always_comb begin
      next_val = count_q;
      at_bound = 1'b0;
      if (bus.up_dn == CNT_UP) begin
         if (count_q == MAX_V) begin
            at_bound = 1'b1;
            next_val = BOUND_UP;
         end else begin
            next_val = count_q + WIDTH'(1'b1);
         end
      end else begin
         if (count_q == '0) begin
            at_bound = 1'b1;
            next_val = BOUND_DN;
         end else begin
            next_val = count_q - WIDTH'(1'b1);
         end
      end
   end

   assign load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;

   // Count, terminal pulse and sticky overflow; clr > load > step > hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.clr) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.load) begin
         count_q <= load_clamped;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (step) begin
         count_q <= next_val;
         tc_q    <= at_bound;
         ovf_q   <= ovf_q | at_bound;
      end else begin
         count_q <= count_q;
         tc_q    <= 1'b0;
         ovf_q   <= ovf_q;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: two configurations driven in parallel,
// directed literal checks plus randomized traffic against a behavioural model.
module tb_param_updown_counter;

`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int W0 = 4, M0 = 9,  P0 = 1;
   localparam int W1 = 5, M1 = 20, P1 = 3;
   localparam int WS [2] = '{W0, W1};
   localparam int MS [2] = '{M0, M1};
   localparam int PS [2] = '{P0, P1};

   typedef struct {
      int cnt;
      int pre;
      bit tc;
      bit ovf;
   } mstate_t;

   logic       clk;
   logic       rst;
   logic       en, up_dn, clr, load;
   logic [4:0] lv;

   int total = 0;
   int bad   = 0;

   param_updown_counter_if #(.WIDTH(W0)) if0 ();
   param_updown_counter_if #(.WIDTH(W1)) if1 ();

   assign if0.en = en;  assign if0.up_dn = up_dn;  assign if0.clr = clr;
   assign if0.load = load;  assign if0.load_val = lv[3:0];
   assign if1.en = en;  assign if1.up_dn = up_dn;  assign if1.clr = clr;
   assign if1.load = load;  assign if1.load_val = lv;

   param_updown_counter #(.WIDTH(W0), .MAX(M0), .PRESCALE(P0)) dut0 (
      .clk (clk), .rst (rst), .bus (if0.slave));
   param_updown_counter #(.WIDTH(W1), .MAX(M1), .PRESCALE(P1)) dut1 (
      .clk (clk), .rst (rst), .bus (if1.slave));

   logic [4:0] d_cnt [2];
   logic       d_tc  [2];
   logic       d_ovf [2];
   assign d_cnt[0] = {1'b0, if0.count};
   assign d_cnt[1] = if1.count;
   assign d_tc[0]  = if0.tc;
   assign d_tc[1]  = if1.tc;
   assign d_ovf[0] = if0.ovf;
   assign d_ovf[1] = if1.ovf;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int d, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, d, $time, act, exp);
      end
   endtask

   // Next model state from the rules: priority, prescale window, bound handling.
   function automatic mstate_t model_next(input int d, input mstate_t s);
      mstate_t n;
      int      lvd;
      n    = s;
      n.tc = 1'b0;
      lvd  = int'(lv) % (1 << WS[d]);
      if (clr) begin
         n.cnt = 0;  n.pre = 0;  n.ovf = 1'b0;
      end else if (load) begin
         n.cnt = (lvd > MS[d]) ? MS[d] : lvd;  n.pre = 0;  n.ovf = 1'b0;
      end else if (en) begin
         n.pre = s.pre + 1;
         if (n.pre == PS[d]) begin
            n.pre = 0;
            if (up_dn) begin
               if (s.cnt == MS[d]) begin
                  n.cnt = SAT ? MS[d] : 0;  n.tc = 1'b1;  n.ovf = 1'b1;
               end else begin
                  n.cnt = s.cnt + 1;
               end
            end else begin
               if (s.cnt == 0) begin
                  n.cnt = SAT ? 0 : MS[d];  n.tc = 1'b1;  n.ovf = 1'b1;
               end else begin
                  n.cnt = s.cnt - 1;
               end
            end
         end
      end
      return n;
   endfunction

   mstate_t m [2];
   initial begin
      for (int d = 0; d < 2; d++) m[d] = '{0, 0, 1'b0, 1'b0};
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) m[d] <= '{0, 0, 1'b0, 1'b0};
      end else begin
         for (int d = 0; d < 2; d++) m[d] <= model_next(d, m[d]);
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk("model_count", d, longint'(d_cnt[d]), longint'(m[d].cnt));
         chk("model_tc",    d, longint'(d_tc[d]),  longint'(m[d].tc));
         chk("model_ovf",   d, longint'(d_ovf[d]), longint'(m[d].ovf));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;  en = 1'b0;  up_dn = 1'b1;  clr = 1'b0;  load = 1'b0;  lv = 5'd0;
      tick();
      chk("reset_count", 0, longint'(d_cnt[0]), 0);
      chk("reset_tc",    0, longint'(d_tc[0]),  0);
      chk("reset_ovf",   1, longint'(d_ovf[1]), 0);
      rst = 1'b1;

      // Up wrap at MAX=9 (saturate build holds 9 and re-pulses tc).
      clr = 1'b1;  tick();  clr = 1'b0;
      en = 1'b1;  up_dn = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("up_count", 0, longint'(d_cnt[0]), (k <= 9) ? k : (SAT ? 9 : k - 10));
         chk("up_tc",    0, longint'(d_tc[0]),  (k == 10 || (SAT && k > 10)) ? 1 : 0);
         chk("up_ovf",   0, longint'(d_ovf[0]), (k >= 10) ? 1 : 0);
      end
      en = 1'b0;  clr = 1'b1;  tick();  clr = 1'b0;
      chk("clr_ovf", 0, longint'(d_ovf[0]), 0);

      // Load clamps 12 to 9, then down steps wrap to 9.
      lv = 5'd12;  load = 1'b1;  tick();  load = 1'b0;
      chk("load_clamp", 0, longint'(d_cnt[0]), 9);
      chk("load_noclamp", 1, longint'(d_cnt[1]), 12);
      en = 1'b1;  up_dn = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("dn_count", 0, longint'(d_cnt[0]), (k <= 9) ? 9 - k : (SAT ? 0 : 9));
         chk("dn_tc",    0, longint'(d_tc[0]),  (k == 10) ? 1 : 0);
      end
      en = 1'b0;

      // clr beats load; load beats step.
      clr = 1'b1;  load = 1'b1;  en = 1'b1;  lv = 5'd5;  tick();
      chk("prio_clr", 0, longint'(d_cnt[0]), 0);
      clr = 1'b0;  tick();
      chk("prio_load", 0, longint'(d_cnt[0]), 5);
      load = 1'b0;  en = 1'b0;  tick();
      chk("prio_hold", 0, longint'(d_cnt[0]), 5);

      // PRESCALE=3: enables 1,1,0,1 give one step; load restarts the window.
      clr = 1'b1;  tick();  clr = 1'b0;  up_dn = 1'b1;
      en = 1'b1;  tick();  chk("ps_a", 1, longint'(d_cnt[1]), 0);
      tick();               chk("ps_b", 1, longint'(d_cnt[1]), 0);
      en = 1'b0;  tick();  chk("ps_c", 1, longint'(d_cnt[1]), 0);
      en = 1'b1;  tick();  chk("ps_d", 1, longint'(d_cnt[1]), 1);
      tick();  tick();      chk("ps_e", 1, longint'(d_cnt[1]), 1);
      lv = 5'd7;  load = 1'b1;  tick();  load = 1'b0;
      chk("ps_load", 1, longint'(d_cnt[1]), 7);
      tick();  tick();      chk("ps_f", 1, longint'(d_cnt[1]), 7);
      tick();               chk("ps_g", 1, longint'(d_cnt[1]), 8);

      // Asynchronous reset mid-count, observed before any edge.
      tick();
      #2 rst = 1'b0;
      #1;
      chk("async_count", 0, longint'(d_cnt[0]), 0);
      chk("async_tc",    0, longint'(d_tc[0]),  0);
      chk("async_ovf",   0, longint'(d_ovf[0]), 0);
      chk("async_count", 1, longint'(d_cnt[1]), 0);
      tick();
      rst = 1'b1;

      // Randomized traffic; the per-cycle compare process does the checking.
      for (int i = 0; i < 3000; i++) begin
         en    = ($urandom_range(0, 9) < 7);
         up_dn = $urandom_range(0, 1) == 1;
         clr   = ($urandom_range(0, 99) < 3);
         load  = ($urandom_range(0, 99) < 5);
         lv    = 5'($urandom_range(0, 31));
         rst   = ($urandom_range(0, 299) != 0);
         tick();
      end
      rst = 1'b1;  en = 1'b0;  clr = 1'b0;  load = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised up/down counter replacing the fixed 32-bit free-running up counter in the sequential counters library. Adds configurable width and terminal value, direction control, synchronous clear and load, count enable with a built-in prescaler, a terminal-count pulse and a sticky overflow flag. It is used as a general event or timebase counter wherever a bare incrementer was used before.

## Interface
- WIDTH, 8: counter width in bits; legal range 2..32.
- MAX, 2**WIDTH-1: terminal value; counting runs over 0..MAX; must satisfy MAX ≤ 2**WIDTH-1.
- PRESCALE, 1: number of enabled cycles per count step; 1 means a step on every enabled cycle; legal range 1..65535.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; feeds the prescaler.
- up_dn  in  1  direction: 1 = up, 0 = down; sampled on each step.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value; values above MAX are clamped to MAX.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse, one cycle wide (registered).
- ovf  out  1  sticky flag for wrap/saturate events (registered).

## Operation
- Reset (rst=0, asynchronous): count=0, tc=0, ovf=0, prescaler=0.
- Per-edge priority: clr > load > step > hold.
- clr: count=0, prescaler=0, ovf=0, tc=0.
- load: count=min(load_val, MAX), prescaler=0, ovf=0, tc=0.
- Prescaler:
  - Increments on each cycle with en=1.
  - When it equals PRESCALE-1 with en=1, it returns to 0 and a step occurs.
  - With en=0, prescaler and count hold.
- Up step:
  - count<MAX: count+1.
  - count==MAX: wrap to 0.
- Down step:
  - count>0: count-1.
  - count==0: wrap to MAX.
- A bound event (up step at MAX, or down step at 0) sets tc=1 for the next cycle and sets ovf=1.
- tc=0 in every other cycle.
- Direction may change between steps with no penalty. up_dn has no effect on non-step cycles.
- No other state machine; behaviour is fully described by the count, prescaler and ovf registers.

## Timing
- count, tc and ovf update on the same edge as the qualifying step, so tc and the wrapped count are visible together.
- Latency: en=1 at edge n (PRESCALE=1) produces the new count after edge n.
- clr/load take effect on the edge they are sampled, regardless of en.
- rst deassertion is synchronised externally; the first step occurs no earlier than the first edge with rst=1.
- Reset asserted mid-prescale discards the partial prescale count.

## Configuration
- Macro: PARAM_UPDOWN_COUNTER_SATURATE_EN.
- Defined: bound events saturate.
  - Up at MAX holds MAX; down at 0 holds 0.
  - tc and ovf still assert exactly as for a wrap.
  - tc re-pulses on every further step attempted at the bound.
- Undefined (default): wrap-around as specified in Operation.

## Structure
- Shared package cnt_pkg holds:
  - Direction constants CNT_DOWN=1'b0 and CNT_UP=1'b1.
  - The parameter legality checks as localparams/functions (clog2 of PRESCALE for the prescaler width).
- One sub-module: cnt_prescaler.
  - Inputs: clk, rst, en, sync_clr.
  - Output: step pulse.
  - Parameter: PRESCALE.
  - At PRESCALE=1 it reduces to step=en.

## Test plan
- Reset with WIDTH=4, MAX=15, PRESCALE=1: rst pulsed low mid-count → count=0, tc=0, ovf=0 immediately, without waiting for an edge.
- Up wrap, MAX=9: en=1, up_dn=1, 10 steps from 0 → count sequence 1..9, then 0; tc high exactly in the cycle count=0; ovf stays 1.
- Down wrap with load, MAX=9: load_val=12 → count=9, ovf=0; then down steps → 8..0, then 9; tc high with count=9.
- Prescaler, PRESCALE=3: en toggled 1,1,0,1 → a single step after the third enabled cycle; load mid-prescale restarts the 3-cycle window.
- Priority: clr=1, load=1, en=1 in the same cycle → count=0; then load=1 with en=1 → count=load_val, with no step that cycle.
- Saturate (macro defined), MAX=15: count=15, three up steps → count stays 15, tc pulses three times, ovf=1; clr → ovf=0.
